// File: rtl/sh_dmac_nch_pkg.sv
// Shared types, register masks and address helpers for the SH7604-style DMA controller.
package SH7604_PKG;

  typedef struct packed {
    logic       ar;
    logic       rl;
    logic [1:0] dm;
    logic [1:0] sm;
    logic [1:0] ts;
    logic       ie;
    logic       te;
    logic       de;
  } CHCR_t;

  typedef struct packed {
    logic ae;
    logic pr;
    logic dme;
  } DMAOR_t;

  // TE and AE are excluded from the write masks: they are write-0-to-clear only.
  localparam logic [10:0] CHCR_INIT   = 11'h000;
  localparam logic [10:0] CHCR_WMASK  = 11'h7FD;
  localparam logic [10:0] CHCR_RMASK  = 11'h7FF;
  localparam logic [2:0]  DMAOR_INIT  = 3'b000;
  localparam logic [2:0]  DMAOR_WMASK = 3'b011;
  localparam logic [2:0]  DMAOR_RMASK = 3'b111;

  typedef enum logic [2:0] {IDLE, ARB, READ, WRITE, UPDATE} dma_state_t;

  function automatic logic [3:0] lane_be(input logic [1:0] a, input logic [1:0] ts);
    if (ts[1])      return 4'b1111;
    else if (ts[0]) return a[1] ? 4'b0011 : 4'b1100;
    else            return 4'b1000 >> a;
  endfunction

  function automatic logic misaligned(input logic [1:0] a, input logic [1:0] ts);
    return ts[1] ? (a != 2'b00) : (ts[0] & a[0]);
  endfunction

  function automatic logic [31:0] addr_step(input logic [31:0] a, input logic [1:0] mode,
                                            input logic [1:0] ts);
    logic [31:0] sz;
    sz = ts[1] ? 32'd4 : (ts[0] ? 32'd2 : 32'd1);
    case (mode)
      2'b01:   return a + sz;
      2'b10:   return a - sz;
      default: return a;
    endcase
  endfunction

  // Big-endian lane pick (address 0 is bits 31:24), then replicate across the bus.
  function automatic logic [31:0] lane_rep(input logic [31:0] d, input logic [1:0] a,
                                           input logic [1:0] ts);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    h = a[1] ? d[15:0] : d[31:16];
    if (ts[1])      return d;
    else if (ts[0]) return {2{h}};
    else            return {4{b}};
  endfunction

endpackage

// File: rtl/sh_dmac_nch_arb.sv
// Channel arbiter: fixed priority (ch0 highest) or round-robin starting after the last grant.
module sh_dmac_arb #(
  parameter  int CH_NUM = 2,
  localparam int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic [CH_NUM-1:0] eligible,
  input  logic              pr,
  input  logic [CH_W-1:0]   last,
  output logic [CH_W-1:0]   grant,
  output logic              valid
);

  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    valid = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      idx = pr ? ((int'(last) + 1 + i) % CH_NUM) : i;
      if (!valid && eligible[idx]) begin
        grant = CH_W'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sh_dmac_nch.sv
// Multi-channel cycle-steal DMA controller: register file, FSM and 32-bit bus master.
module sh_dmac_nch
  import SH7604_PKG::*;
#(
  parameter int CH_NUM = 2,
  parameter int TCR_W  = 24
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE,
  input  logic [CH_NUM-1:0] DREQ,
  output logic [CH_NUM-1:0] DACK,
  input  logic [7:0]        REG_A,
  input  logic [31:0]       REG_DI,
  input  logic              REG_WE,
  input  logic              REG_REQ,
  output logic [31:0]       REG_DO,
  output logic [31:0]       DBUS_A,
  output logic [31:0]       DBUS_DO,
  output logic [3:0]        DBUS_BA,
  output logic              DBUS_WE,
  output logic              DBUS_REQ,
  input  logic [31:0]       DBUS_DI,
  input  logic              DBUS_WAIT,
  output logic [CH_NUM-1:0] IRQ
);

  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic [31:0]      sar    [CH_NUM];
  logic [31:0]      dar    [CH_NUM];
  logic [TCR_W-1:0] tcr    [CH_NUM];
  logic [31:0]      sar_sh [CH_NUM];
  logic [31:0]      dar_sh [CH_NUM];
  logic [TCR_W-1:0] tcr_sh [CH_NUM];
  CHCR_t            chcr   [CH_NUM];
  DMAOR_t           dmaor;

  logic [CH_NUM-1:0] dreq_sync;
  logic [CH_NUM-1:0] te_clr;
  logic [CH_NUM-1:0] eligible;
  dma_state_t        state, state_nx;
  logic [CH_W-1:0]   ch, rr_last, arb_last, arb_grant;
  logic              rr_valid, arb_valid, arb_misal;
  logic [31:0]       xfer_data, rd_data;
  logic [TCR_W-1:0]  tcr_dec;
  logic              reg_rd, reg_wr, dmaor_hit;

  assign reg_rd    = REG_REQ & ~REG_WE;
  assign reg_wr    = REG_REQ & REG_WE;
  assign dmaor_hit = (REG_A == 8'(16 * CH_NUM));
  assign tcr_dec   = tcr[ch] - TCR_W'(1);

  always_comb begin
    eligible = '0;
    IRQ      = '0;
    for (int n = 0; n < CH_NUM; n++) begin
      eligible[n] = dmaor.dme & chcr[n].de & ~chcr[n].te & ~dmaor.ae &
                    (chcr[n].ar | dreq_sync[n]);
      IRQ[n]      = chcr[n].te & chcr[n].ie;
    end
  end

  // Before the first grant, pretend the last channel was served so the search starts at 0.
  assign arb_last = rr_valid ? rr_last : CH_W'(CH_NUM - 1);

  sh_dmac_arb #(.CH_NUM(CH_NUM)) u_arb (
    .eligible (eligible),
    .pr       (dmaor.pr),
    .last     (arb_last),
    .grant    (arb_grant),
    .valid    (arb_valid)
  );

  assign arb_misal = misaligned(sar[arb_grant][1:0], chcr[arb_grant].ts) |
                     misaligned(dar[arb_grant][1:0], chcr[arb_grant].ts);

  always_comb begin
    rd_data = '0;
    for (int n = 0; n < CH_NUM; n++) begin
      if (REG_A[7:4] == 4'(n) && REG_A[1:0] == 2'b00) begin
        case (REG_A[3:2])
          2'd0:    rd_data = sar[n];
          2'd1:    rd_data = dar[n];
          2'd2:    rd_data = 32'(tcr[n]);
          default: rd_data = 32'(chcr[n] & CHCR_RMASK);
        endcase
      end
    end
    if (dmaor_hit) rd_data = 32'(dmaor & DMAOR_RMASK);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else if (CE) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    DBUS_REQ = 1'b0;
    DBUS_WE  = 1'b0;
    DBUS_A   = '0;
    DBUS_DO  = '0;
    DBUS_BA  = '0;
    DACK     = '0;
    case (state)
      IDLE:   if (|eligible) state_nx = ARB;
      ARB:    state_nx = (arb_valid && !arb_misal) ? READ : IDLE;
      READ: begin
        DBUS_REQ = 1'b1;
        DBUS_A   = sar[ch];
        DBUS_BA  = lane_be(sar[ch][1:0], chcr[ch].ts);
        DACK[ch] = 1'b1;
        if (!DBUS_WAIT) state_nx = WRITE;
      end
      WRITE: begin
        DBUS_REQ = 1'b1;
        DBUS_WE  = 1'b1;
        DBUS_A   = dar[ch];
        DBUS_DO  = xfer_data;
        DBUS_BA  = lane_be(dar[ch][1:0], chcr[ch].ts);
        DACK[ch] = 1'b1;
        if (!DBUS_WAIT) state_nx = UPDATE;
      end
      UPDATE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CE && state == READ && !DBUS_WAIT)
      xfer_data <= lane_rep(DBUS_DI, sar[ch][1:0], chcr[ch].ts);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int n = 0; n < CH_NUM; n++) begin
        sar[n]    <= '0;
        dar[n]    <= '0;
        tcr[n]    <= '0;
        sar_sh[n] <= '0;
        dar_sh[n] <= '0;
        tcr_sh[n] <= '0;
        chcr[n]   <= CHCR_t'(CHCR_INIT);
      end
      dmaor     <= DMAOR_t'(DMAOR_INIT);
      dreq_sync <= '0;
      te_clr    <= '0;
      ch        <= '0;
      rr_last   <= '0;
      rr_valid  <= 1'b0;
      REG_DO    <= '0;
    end else if (CE) begin
      dreq_sync <= DREQ;
      te_clr    <= '0;
      if (reg_rd) REG_DO <= rd_data;
      for (int n = 0; n < CH_NUM; n++)
        if (te_clr[n]) chcr[n].te <= 1'b0;

      if (state == ARB && arb_valid) begin
        if (arb_misal) dmaor.ae <= 1'b1;
        else begin
          ch       <= arb_grant;
          rr_last  <= arb_grant;
          rr_valid <= 1'b1;
        end
      end

      if (state == UPDATE) begin
        sar[ch] <= addr_step(sar[ch], chcr[ch].sm, chcr[ch].ts);
        dar[ch] <= addr_step(dar[ch], chcr[ch].dm, chcr[ch].ts);
        tcr[ch] <= tcr_dec;
        if (tcr_dec == '0) begin
          chcr[ch].te <= 1'b1;
          if (chcr[ch].rl) begin
            sar[ch]    <= sar_sh[ch];
            dar[ch]    <= dar_sh[ch];
            tcr[ch]    <= tcr_sh[ch];
            te_clr[ch] <= 1'b1;
          end
        end
      end

      // CPU writes come last so they override the UPDATE result.
      if (reg_wr) begin
        for (int n = 0; n < CH_NUM; n++) begin
          if (REG_A[7:4] == 4'(n) && REG_A[1:0] == 2'b00) begin
            case (REG_A[3:2])
              2'd0: begin sar[n] <= REG_DI; sar_sh[n] <= REG_DI; end
              2'd1: begin dar[n] <= REG_DI; dar_sh[n] <= REG_DI; end
              2'd2: begin tcr[n] <= REG_DI[TCR_W-1:0]; tcr_sh[n] <= REG_DI[TCR_W-1:0]; end
              default: chcr[n] <= CHCR_t'((REG_DI[10:0] & CHCR_WMASK) |
                                          {9'b0, chcr[n].te & REG_DI[1], 1'b0});
            endcase
          end
        end
        if (dmaor_hit)
          dmaor <= DMAOR_t'((REG_DI[2:0] & DMAOR_WMASK) | {dmaor.ae & REG_DI[2], 2'b00});
      end
    end
  end

endmodule

// File: tb/tb_sh_dmac_nch.sv
// Directed bench for sh_dmac_nch (4 channels): transfers, arbitration, reload, alignment, reset.
module tb_sh_dmac_nch;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CE = 1'b1;
  logic [3:0]  DREQ = '0;
  logic [3:0]  DACK;
  logic [7:0]  REG_A = '0;
  logic [31:0] REG_DI = '0;
  logic        REG_WE = 1'b0;
  logic        REG_REQ = 1'b0;
  logic [31:0] REG_DO;
  logic [31:0] DBUS_A, DBUS_DO, DBUS_DI;
  logic [3:0]  DBUS_BA;
  logic        DBUS_WE, DBUS_REQ;
  logic        DBUS_WAIT = 1'b0;
  logic [3:0]  IRQ;

  localparam logic [7:0] DMAOR_A = 8'h40;

  sh_dmac_nch #(.CH_NUM(4), .TCR_W(24)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .DREQ(DREQ), .DACK(DACK),
    .REG_A(REG_A), .REG_DI(REG_DI), .REG_WE(REG_WE), .REG_REQ(REG_REQ), .REG_DO(REG_DO),
    .DBUS_A(DBUS_A), .DBUS_DO(DBUS_DO), .DBUS_BA(DBUS_BA), .DBUS_WE(DBUS_WE),
    .DBUS_REQ(DBUS_REQ), .DBUS_DI(DBUS_DI), .DBUS_WAIT(DBUS_WAIT), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  // Memory model: read data derived from the address.
  assign DBUS_DI = {DBUS_A[15:0] ^ 16'hA5A5, DBUS_A[15:0]};

  logic [31:0] t_a [256];
  logic [31:0] t_d [256];
  logic        t_we [256];
  logic [3:0]  t_ba [256];
  logic [3:0]  t_dack [256];
  int n_txn = 0, req_cycles = 0, irq_run = 0, irq_pulses = 0, irq_last = 0;
  int checks = 0, errors = 0;

  always @(posedge CLK) begin
    if (RST_N && CE && DBUS_REQ && !DBUS_WAIT && n_txn < 256) begin
      t_a[n_txn]    <= DBUS_A;
      t_d[n_txn]    <= DBUS_WE ? DBUS_DO : DBUS_DI;
      t_we[n_txn]   <= DBUS_WE;
      t_ba[n_txn]   <= DBUS_BA;
      t_dack[n_txn] <= DACK;
      n_txn         <= n_txn + 1;
    end
    if (DBUS_REQ) req_cycles <= req_cycles + 1;
    if (IRQ[0]) irq_run <= irq_run + 1;
    else if (irq_run > 0) begin
      irq_pulses <= irq_pulses + 1;
      irq_last   <= irq_run;
      irq_run    <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge CLK);
    REG_A = a; REG_DI = d; REG_WE = 1'b1; REG_REQ = 1'b1;
    @(negedge CLK);
    REG_WE = 1'b0; REG_REQ = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    @(negedge CLK);
    REG_A = a; REG_WE = 1'b0; REG_REQ = 1'b1;
    @(negedge CLK);
    REG_REQ = 1'b0;
    chk(tag, REG_DO, exp);
  endtask

  task automatic wait_txn(input int n, input int budget);
    int k;
    k = 0;
    while (n_txn < n && k < budget) begin
      @(negedge CLK);
      k++;
    end
    chk($sformatf("wait_txn_%0d", n), 32'(n_txn >= n), 32'd1);
  endtask

  task automatic setup_four(input logic [31:0] dmaor_val);
    for (int c = 0; c < 4; c++) begin
      reg_wr(8'(16 * c),     32'h1000 + 32'(c) * 32'h100);
      reg_wr(8'(16 * c + 4), 32'h2000 + 32'(c) * 32'h100);
      reg_wr(8'(16 * c + 8), 32'd2);
      reg_wr(8'(16 * c + 12), 32'h411);
    end
    reg_wr(DMAOR_A, dmaor_val);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_d [3];
    logic [3:0]  exp_rr [8];
    logic [3:0]  exp_fx [8];
    int base, k, rc, p0;
    exp_d  = '{32'hA4A50100, 32'hA4A10104, 32'hA4AD0108};
    exp_rr = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    exp_fx = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8};

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_dbus_req", DBUS_REQ, 0);
    chk("rst_dack", DACK, 0);
    chk("rst_irq", IRQ, 0);
    chk("rst_reg_do", REG_DO, 0);
    RST_N = 1'b1;
    rd_chk("rst_dmaor", DMAOR_A, 0);
    rd_chk("rst_chcr0", 8'h0C, 0);
    reg_wr(8'h44, 32'hFFFF_FFFF);
    rd_chk("unmapped_rd", 8'h44, 0);

    // Long, incrementing, 3 units on ch0
    base = n_txn;
    reg_wr(8'h00, 32'h100);
    reg_wr(8'h04, 32'h200);
    reg_wr(8'h08, 32'd3);
    reg_wr(8'h0C, 32'h4B5);
    reg_wr(DMAOR_A, 32'h1);
    wait_txn(base + 6, 200);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("a_rd%0d_addr", u), t_a[base + 2*u], 32'h100 + 32'(4*u));
      chk($sformatf("a_rd%0d_we", u), t_we[base + 2*u], 0);
      chk($sformatf("a_rd%0d_ba", u), t_ba[base + 2*u], 4'hF);
      chk($sformatf("a_wr%0d_addr", u), t_a[base + 2*u + 1], 32'h200 + 32'(4*u));
      chk($sformatf("a_wr%0d_we", u), t_we[base + 2*u + 1], 1);
      chk($sformatf("a_wr%0d_data", u), t_d[base + 2*u + 1], exp_d[u]);
    end
    repeat (4) @(negedge CLK);
    chk("a_irq", IRQ, 4'b0001);
    chk("a_no_extra", n_txn, base + 6);
    rd_chk("a_chcr0", 8'h0C, 32'h4B7);
    rd_chk("a_sar0", 8'h00, 32'h10C);
    rd_chk("a_dar0", 8'h04, 32'h20C);
    rd_chk("a_tcr0", 8'h08, 0);

    // DREQ-driven ch1: latency, and DREQ drop does not abort the unit
    base = n_txn;
    reg_wr(8'h10, 32'h500);
    reg_wr(8'h14, 32'h600);
    reg_wr(8'h18, 32'd1);
    reg_wr(8'h1C, 32'h011);
    @(negedge CLK);
    DREQ[1] = 1'b1;
    k = 0;
    while (!DBUS_REQ && k < 10) begin
      @(posedge CLK);
      #1;
      k++;
    end
    chk("b_latency", k, 3);
    chk("b_dack", DACK, 4'b0010);
    chk("b_addr", DBUS_A, 32'h500);
    @(negedge CLK);
    DREQ[1] = 1'b0;
    wait_txn(base + 2, 50);
    chk("b_wr_addr", t_a[base + 1], 32'h600);
    repeat (3) @(negedge CLK);
    rd_chk("b_chcr1", 8'h1C, 32'h013);

    // Round-robin grant order
    do_reset();
    base = n_txn;
    setup_four(32'h3);
    wait_txn(base + 16, 400);
    for (int u = 0; u < 8; u++)
      chk($sformatf("rr_grant%0d", u), t_dack[base + 2*u], exp_rr[u]);
    repeat (3) @(negedge CLK);
    rd_chk("rr_tcr3", 8'h38, 0);

    // Fixed priority grant order
    do_reset();
    base = n_txn;
    setup_four(32'h1);
    wait_txn(base + 16, 400);
    for (int u = 0; u < 8; u++)
      chk($sformatf("fx_grant%0d", u), t_dack[base + 2*u], exp_fx[u]);

    // Reload
    do_reset();
    base = n_txn;
    reg_wr(8'h00, 32'h40);
    reg_wr(8'h04, 32'h80);
    reg_wr(8'h08, 32'd2);
    reg_wr(8'h0C, 32'h635);
    p0 = irq_pulses;
    reg_wr(DMAOR_A, 32'h1);
    wait_txn(base + 4, 100);
    reg_wr(DMAOR_A, 32'h0);
    repeat (4) @(negedge CLK);
    chk("rl_rd0", t_a[base], 32'h40);
    chk("rl_rd1", t_a[base + 2], 32'h44);
    chk("rl_irq_pulses", irq_pulses - p0, 1);
    chk("rl_irq_width", irq_last, 1);
    rd_chk("rl_sar0", 8'h00, 32'h40);
    rd_chk("rl_tcr0", 8'h08, 32'd2);
    rd_chk("rl_dar0", 8'h04, 32'h80);
    rd_chk("rl_chcr0", 8'h0C, 32'h635);
    reg_wr(DMAOR_A, 32'h1);
    wait_txn(base + 5, 50);
    chk("rl_continue", t_a[base + 4], 32'h40);

    // Misaligned word source
    do_reset();
    base = n_txn;
    reg_wr(8'h00, 32'h101);
    reg_wr(8'h04, 32'h200);
    reg_wr(8'h08, 32'd1);
    reg_wr(8'h0C, 32'h409);
    rc = req_cycles;
    reg_wr(DMAOR_A, 32'h1);
    repeat (10) @(negedge CLK);
    chk("ae_no_req", req_cycles, rc);
    rd_chk("ae_dmaor", DMAOR_A, 32'h5);
    reg_wr(8'h00, 32'h100);
    reg_wr(DMAOR_A, 32'h1);
    wait_txn(base + 2, 50);
    chk("ae_rd_addr", t_a[base], 32'h100);
    chk("ae_rd_ba", t_ba[base], 4'b1100);
    chk("ae_wr_addr", t_a[base + 1], 32'h200);
    chk("ae_wr_ba", t_ba[base + 1], 4'b1100);
    chk("ae_wr_data", t_d[base + 1], 32'hA4A5A4A5);

    // Wait states in READ, then reset during WRITE
    do_reset();
    base = n_txn;
    DBUS_WAIT = 1'b1;
    reg_wr(8'h00, 32'h300);
    reg_wr(8'h04, 32'h400);
    reg_wr(8'h08, 32'd1);
    reg_wr(8'h0C, 32'h411);
    reg_wr(DMAOR_A, 32'h1);
    k = 0;
    while (!DBUS_REQ && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("w_req", DBUS_REQ, 1);
    chk("w_rd_we", DBUS_WE, 0);
    chk("w_rd_addr", DBUS_A, 32'h300);
    repeat (4) @(negedge CLK);
    chk("w_hold_req", DBUS_REQ, 1);
    chk("w_hold_addr", DBUS_A, 32'h300);
    chk("w_hold_we", DBUS_WE, 0);
    DBUS_WAIT = 1'b0;
    @(negedge CLK);
    DBUS_WAIT = 1'b1;
    chk("w_wr_we", DBUS_WE, 1);
    chk("w_wr_addr", DBUS_A, 32'h400);
    chk("w_wr_data", DBUS_DO, 32'hA6A50300);
    #2 RST_N = 1'b0;
    #1;
    chk("w_rst_req", DBUS_REQ, 0);
    chk("w_rst_dack", DACK, 0);
    chk("w_rst_addr", DBUS_A, 0);
    chk("w_rst_do", DBUS_DO, 0);
    chk("w_rst_we", DBUS_WE, 0);
    chk("w_rst_ba", DBUS_BA, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    DBUS_WAIT = 1'b0;
    repeat (3) @(negedge CLK);
    chk("w_only_read", n_txn, base + 1);
    rd_chk("w_sar0", 8'h00, 0);
    rd_chk("w_dar0", 8'h04, 0);
    rd_chk("w_tcr0", 8'h08, 0);
    rd_chk("w_chcr0", 8'h0C, 0);
    rd_chk("w_dmaor", DMAOR_A, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
